fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/pipeline_pkg.sv | 19 +
 rtl/fetch_wdog.sv | 30 +++
 rtl/fetch_ctrl.sv | 116 +++++++++++
 tb/tb_fetch_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared fetch-pipeline types: fetch FSM state encoding, watchdog width and
// the word-alignment helper used by the fetch controller.
package pipeline_pkg;

    localparam int FETCH_WAIT_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        ERR   = 3'd4
    } fetch_state_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_wdog.sv
// Fetch watchdog: counts consecutive not-ready cycles and flags the cycle on
// which the count would reach MAX_WAIT.
module fetch_wdog
    import pipeline_pkg::*;
#(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expire
);

    logic [FETCH_WAIT_W-1:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Fires on the MAX_WAIT-th consecutive miss so the FSM leaves on that edge.
    assign expire = inc && (cnt == FETCH_WAIT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch PC controller with redirect draining and not-ready timeout.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets instead of aligning them.
module fetch_ctrl
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        imem_ready,
    output logic [31:0] PCF,
    output logic        imem_req,
    output logic        fetch_valid,
    output logic        fetch_err,
    output logic        misalign
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_q, pend_d;
    logic [31:0]  tgt;
    logic         bad_tgt;
    logic         active;
    logic         issuing;
    logic         mis_set;
    logic         expire;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic mis_q;

    assign tgt     = PCTargetE;
    assign bad_tgt = PCSrcE && (PCTargetE[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            mis_q <= 1'b0;
        end else if (mis_set) begin
            mis_q <= 1'b1;
        end
    end

    assign misalign = mis_q;
`else
    assign tgt      = align_word(PCTargetE);
    assign bad_tgt  = 1'b0;
    assign misalign = 1'b0;
`endif

    assign active  = (state_q == FETCH) || (state_q == WAIT) || (state_q == DRAIN);
    assign issuing = (state_q == FETCH) || (state_q == WAIT);

    fetch_wdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (!(active && !imem_ready)),
        .inc    (active && !imem_ready),
        .expire (expire)
    );

    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        mis_set = 1'b0;
        unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH, WAIT, DRAIN: begin
                if (bad_tgt) begin
                    state_d = ERR;
                    mis_set = 1'b1;
                end else if (expire) begin
                    state_d = ERR;
                end else if (imem_ready) begin
                    state_d = FETCH;
                    if (PCSrcE)                pc_d = tgt;
                    else if (state_q == DRAIN) pc_d = pend_q;
                    else if (!StallF)          pc_d = pc_q + 32'd4;
                end else if (PCSrcE) begin
                    // Memory still owes a response for the old PC; park the target.
                    pend_d  = tgt;
                    state_d = DRAIN;
                end else if (state_q != DRAIN) begin
                    state_d = WAIT;
                end
            end
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
        end
    end

    assign PCF         = pc_q;
    assign imem_req    = !reset && active;
    assign fetch_valid = !reset && issuing && imem_ready && !PCSrcE;
    assign fetch_err   = (state_q == ERR);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: abstract port-level model compared every
// cycle, plus directed scenarios with hand-computed pinned expectations.
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          MAX_WAIT = 8;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    // Model modes: FETCH and WAIT look identical at the ports, so one "run" mode.
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_ERR   = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_ready;
    logic [31:0] PCF;
    logic        imem_req;
    logic        fetch_valid;
    logic        fetch_err;
    logic        misalign;

    fetch_ctrl #(
        .RESET_PC (RESET_PC),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .StallF      (StallF),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .imem_ready  (imem_ready),
        .PCF         (PCF),
        .imem_req    (imem_req),
        .fetch_valid (fetch_valid),
        .fetch_err   (fetch_err),
        .misalign    (misalign)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;

    int          m_mode  = M_IDLE;
    logic [31:0] m_pc    = '0;
    logic [31:0] m_pend  = '0;
    int          m_miss  = 0;
    bit          m_err   = 1'b0;
    bit          m_mis   = 1'b0;
    bit          model_ok = 1'b0;

    bit          pin_en = 1'b0;
    string       pin_tag = "";
    logic [31:0] pin_pc;
    logic        pin_req, pin_valid, pin_err, pin_mis;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Port-level model: advances on each rising edge from the sampled inputs.
    always @(posedge clk) begin
        if (reset) begin
            m_mode   <= M_IDLE;
            m_pc     <= RESET_PC;
            m_pend   <= '0;
            m_miss   <= 0;
            m_err    <= 1'b0;
            m_mis    <= 1'b0;
            model_ok <= 1'b1;
        end else if (model_ok) begin
            case (m_mode)
                M_IDLE: m_mode <= M_RUN;
                M_RUN, M_DRAIN: begin
                    if (TRAP && PCSrcE && PCTargetE[1:0] != 2'b00) begin
                        m_mode <= M_ERR;
                        m_err  <= 1'b1;
                        m_mis  <= 1'b1;
                    end else if (!imem_ready && m_miss + 1 >= MAX_WAIT) begin
                        m_mode <= M_ERR;
                        m_err  <= 1'b1;
                    end else if (imem_ready) begin
                        m_miss <= 0;
                        m_mode <= M_RUN;
                        if (PCSrcE)                 m_pc <= PCTargetE & ~32'h3;
                        else if (m_mode == M_DRAIN) m_pc <= m_pend;
                        else if (!StallF)           m_pc <= m_pc + 32'd4;
                    end else begin
                        m_miss <= m_miss + 1;
                        if (PCSrcE) begin
                            m_pend <= PCTargetE & ~32'h3;
                            m_mode <= M_DRAIN;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Compare process: model vs DUT every cycle, plus any pinned literal values.
    always @(negedge clk) begin
        if (model_ok) begin
            check("pc",    PCF, m_pc);
            check("req",   {31'd0, imem_req},
                  {31'd0, !reset && (m_mode == M_RUN || m_mode == M_DRAIN)});
            check("valid", {31'd0, fetch_valid},
                  {31'd0, !reset && m_mode == M_RUN && imem_ready && !PCSrcE});
            check("err",   {31'd0, fetch_err}, {31'd0, m_err});
            check("mis",   {31'd0, misalign},  {31'd0, m_mis});
        end
        if (pin_en) begin
            check({pin_tag, ".pc"},    PCF, pin_pc);
            check({pin_tag, ".req"},   {31'd0, imem_req},    {31'd0, pin_req});
            check({pin_tag, ".valid"}, {31'd0, fetch_valid}, {31'd0, pin_valid});
            check({pin_tag, ".err"},   {31'd0, fetch_err},   {31'd0, pin_err});
            check({pin_tag, ".mis"},   {31'd0, misalign},    {31'd0, pin_mis});
        end
    end

    // Pins expectations for the current cycle, then advances one clock.
    task automatic expect_now(input string tag, input logic [31:0] pc, input logic req,
                              input logic valid, input logic err, input logic mis);
        pin_tag   = tag;
        pin_pc    = pc;
        pin_req   = req;
        pin_valid = valid;
        pin_err   = err;
        pin_mis   = mis;
        pin_en    = 1'b1;
        @(negedge clk);
        #1 pin_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        StallF     = 1'b0;
        PCSrcE     = 1'b0;
        PCTargetE  = '0;
        imem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Sequential fetch after reset.
        reset = 1'b0;
        expect_now("idle", RESET_PC, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_now("seq0", 32'h0,  1'b1, 1'b1, 1'b0, 1'b0);
        expect_now("seq4", 32'h4,  1'b1, 1'b1, 1'b0, 1'b0);
        expect_now("seq8", 32'h8,  1'b1, 1'b1, 1'b0, 1'b0);
        expect_now("seqc", 32'hC,  1'b1, 1'b1, 1'b0, 1'b0);

        // Stall holds the PC; redirect wins over stall.
        StallF = 1'b1;
        for (int i = 0; i < 3; i++) expect_now("stall", 32'h10, 1'b1, 1'b1, 1'b0, 1'b0);
        PCSrcE = 1'b1; PCTargetE = 32'h80;
        expect_now("stall_redir", 32'h10, 1'b1, 1'b0, 1'b0, 1'b0);
        PCSrcE = 1'b0; StallF = 1'b0;
        expect_now("redir_tgt", 32'h80, 1'b1, 1'b1, 1'b0, 1'b0);

        // Drain: two redirects while memory is busy, newest target wins.
        PCSrcE = 1'b1; PCTargetE = 32'h20;
        expect_now("to_20", 32'h84, 1'b1, 1'b0, 1'b0, 1'b0);
        PCSrcE = 1'b0; imem_ready = 1'b0;
        expect_now("busy_20", 32'h20, 1'b1, 1'b0, 1'b0, 1'b0);
        PCSrcE = 1'b1; PCTargetE = 32'h40;
        expect_now("drain_40", 32'h20, 1'b1, 1'b0, 1'b0, 1'b0);
        PCTargetE = 32'h60;
        expect_now("drain_60", 32'h20, 1'b1, 1'b0, 1'b0, 1'b0);
        PCSrcE = 1'b0; imem_ready = 1'b1;
        expect_now("drain_rdy", 32'h20, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_now("drain_done", 32'h60, 1'b1, 1'b1, 1'b0, 1'b0);

        // Misaligned redirect.
        PCSrcE = 1'b1; PCTargetE = 32'h102;
        expect_now("mis_redir", 32'h64, 1'b1, 1'b0, 1'b0, 1'b0);
        PCSrcE = 1'b0;
        if (TRAP) expect_now("mis_trap",  32'h64,  1'b0, 1'b0, 1'b1, 1'b1);
        else      expect_now("mis_align", 32'h100, 1'b1, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        expect_now("rst_a", TRAP ? 32'h64 : 32'h104, 1'b0, 1'b0, TRAP, TRAP);
        reset = 1'b0;
        expect_now("idle2",   RESET_PC, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_now("refetch", 32'h0,    1'b1, 1'b1, 1'b0, 1'b0);

        // Wrap at the top of the address space.
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
        expect_now("wrap_redir", 32'h4, 1'b1, 1'b0, 1'b0, 1'b0);
        PCSrcE = 1'b0;
        expect_now("wrap_top",  32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_now("wrap_zero", 32'h0,         1'b1, 1'b1, 1'b0, 1'b0);

        // Timeout after MAX_WAIT misses; ERR absorbs until reset.
        imem_ready = 1'b0;
        for (int i = 0; i < MAX_WAIT; i++) expect_now("tmo_wait", 32'h4, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_now("tmo_err", 32'h4, 1'b0, 1'b0, 1'b1, 1'b0);
        imem_ready = 1'b1;
        expect_now("err_hold", 32'h4, 1'b0, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        expect_now("rst_b", 32'h4, 1'b0, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        expect_now("idle3",   RESET_PC, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_now("restart", 32'h0,    1'b1, 1'b1, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
